reset_sequencer: RTL
====================

# reset_sequencer

Staged reset-release and initialization sequencer for the ray-tracing pipeline. It sits directly downstream of the power-on reset source. It holds every pipeline unit in reset for a fixed interval, then releases the units one at a time in index order. Each unit gets a one-cycle init start pulse, and the sequencer waits for that unit's init-done acknowledgement (with timeout) before releasing the next. It reports system-ready when all stages are up, and raises a latched fault on any timeout.

## Interface
- NUM_STAGES, 4, number of sequenced units (≥1); stage 0 is released first
- HOLD_CYCLES, 16, cycles all stages stay in reset after `rst` deasserts (≥1)
- TIMEOUT_CYCLES, 1024, max cycles to wait for a stage's init_done (≥1)
- clk  in  1  single system clock; everything is in this domain
- rst  in  1  asynchronous, active-high reset
- stage_rst  out  NUM_STAGES  per-stage reset, active-high
- init_start  out  NUM_STAGES  one-cycle init pulse for the stage being released
- init_done  in  NUM_STAGES  per-stage init-complete level; bit i is only sampled while waiting on stage i
- retry  in  1  single-cycle request to rerun the sequence; honoured only in FAULT
- sys_ready  out  1  high once all stages have acknowledged
- fault  out  1  latched timeout indication
- fault_stage  out  $clog2(NUM_STAGES) (min 1)  index of the stage that timed out

## Operation
- All outputs are registered.
- While `rst` is high:
  - stage_rst is all ones.
  - init_start, sys_ready, fault and fault_stage are all zero.
  - The state is HOLD and the counter is cleared.
- States: HOLD, LAUNCH, WAIT, DONE, FAULT. The state enum is 3 bits.
- HOLD: all stage_rst bits high. The counter increments each cycle. Once HOLD_CYCLES cycles have elapsed, go to LAUNCH with stage index = 0.
- LAUNCH (exactly one cycle):
  - stage_rst[idx] is low.
  - stage_rst bits below idx stay low; bits above idx stay high.
  - init_start[idx] is high; all other init_start bits are low.
  - Clear the counter, then go to WAIT.
- WAIT: sample init_done[idx] at each rising edge.
  - If high: go to DONE when idx == NUM_STAGES-1; otherwise increment idx and go to LAUNCH.
  - If low and the counter has reached TIMEOUT_CYCLES-1: go to FAULT.
  - Otherwise increment the counter.
- DONE: sys_ready stays high and stage_rst stays all zero. DONE is terminal until `rst`.
- FAULT:
  - fault = 1, fault_stage = idx, sys_ready = 0.
  - stage_rst is reasserted to all ones.
  - retry = 1: clear fault and fault_stage, clear the counter, go to HOLD, idx = 0.
- retry is ignored in every state except FAULT.
- init_done bits other than the current idx are ignored, including bits that are stuck high.

## Timing
- Define cycle 1 as the first rising edge after `rst` deasserts.
- stage_rst[0] falls and init_start[0] rises on edge HOLD_CYCLES. init_start[0] is high for exactly one cycle.
- WAIT starts on the next edge.
- If init_done[i] is high at WAIT edge k:
  - LAUNCH of stage i+1 is visible after edge k.
  - For the last stage, sys_ready rises after edge k.
- Minimum stage-to-stage spacing is 2 cycles: LAUNCH, then one WAIT cycle.
- Timeout: if done never arrives, FAULT is entered on the TIMEOUT_CYCLES-th WAIT edge. fault and fault_stage are visible after that edge.
- If done and timeout occur on the same edge, done wins.
- retry in FAULT: HOLD starts on the next edge, and the full HOLD_CYCLES interval repeats.
- `rst` asserted mid-sequence (any state) immediately forces the reset values asynchronously, with no glitch to sys_ready.
- Counter width is $clog2(max(HOLD_CYCLES, TIMEOUT_CYCLES)+1). The counter never wraps; it saturates by construction.

## Structure
- Package `reset_seq_pkg`: the state_t enum (HOLD, LAUNCH, WAIT, DONE, FAULT) and the default parameter constants.
- Sub-module `cycle_timer`:
  - Parameterised count width.
  - Inputs: clear, enable, terminal value.
  - Output: registered expired flag.
  - Shared by HOLD and WAIT.
- Top level holds the FSM, the idx register and the output registers.

## Test plan
- Defaults, all stages ack 3 cycles after their init_start:
  - stage_rst[0] falls at cycle 16.
  - Each init_start is a one-cycle pulse.
  - sys_ready rises after stage 3's ack.
  - fault stays 0.
- init_done[2] never asserts, TIMEOUT_CYCLES=8:
  - fault=1 and fault_stage=2 after 8 WAIT edges.
  - stage_rst returns to 4'b1111.
  - sys_ready=0.
- After that fault, pulse retry and then ack all stages:
  - fault clears on the next edge.
  - The 16-cycle HOLD repeats.
  - sys_ready=1 at the end.
- init_done[3] tied high from reset while stage 0 is pending:
  - Stage 3 does not launch early.
  - Release order is still 0, 1, 2, 3.
- Assert rst during WAIT on stage 1:
  - stage_rst=4'b1111, init_start=0, sys_ready=0 immediately.
  - The sequence restarts from HOLD.
- Ack arrives on the same edge as the timeout expiry (TIMEOUT_CYCLES=4, done on the 4th WAIT edge):
  - No fault; the next stage launches.
- retry pulsed in DONE: no effect.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - state enum, default constants and width helpers for reset_sequencer
package reset_seq_pkg;

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_LAUNCH,
      ST_WAIT,
      ST_DONE,
      ST_FAULT
   } state_t;

   localparam int DEF_NUM_STAGES     = 4;
   localparam int DEF_HOLD_CYCLES    = 16;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int hold, input int timeout);
      return $clog2(((hold > timeout) ? hold : timeout) + 1);
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - saturating cycle counter with a registered expired flag
// expired reflects the counter value after the same edge, so the owner can act on the following edge.
module cycle_timer #(
   parameter int   CW            = 8,
   parameter logic RESET_EXPIRED = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          enable,
   input  logic [CW-1:0] terminal,
   output logic          expired
);

   logic [CW-1:0] count;
   logic [CW-1:0] count_next;

   always_comb begin
      count_next = count;
      if (clear) begin
         count_next = '0;
      end else if (enable && (count != {CW{1'b1}})) begin
         count_next = count + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         expired <= RESET_EXPIRED;
      end else begin
         count   <= count_next;
         expired <= (count_next >= terminal);
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release with per-stage init handshake and timeout fault
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES     = DEF_NUM_STAGES,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   localparam int IW            = idx_width(NUM_STAGES)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [NUM_STAGES-1:0] stage_rst,
   output logic [NUM_STAGES-1:0] init_start,
   input  logic [NUM_STAGES-1:0] init_done,
   input  logic                  retry,
   output logic                  sys_ready,
   output logic                  fault,
   output logic [IW-1:0]         fault_stage
);

   localparam int            CW        = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CW-1:0] HOLD_TERM = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] WAIT_TERM = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);

   state_t                  state, state_n;
   logic [IW-1:0]           idx, idx_n;
   logic                    expired;
   logic [CW-1:0]           terminal;
   logic [NUM_STAGES-1:0]   stage_rst_d;
   logic [NUM_STAGES-1:0]   init_start_d;

   always_comb begin
      state_n = state;
      idx_n   = idx;
      case (state)
         ST_HOLD: begin
            if (expired) begin
               state_n = ST_LAUNCH;
               idx_n   = '0;
            end
         end
         ST_LAUNCH: state_n = ST_WAIT;
         ST_WAIT: begin
            // done takes priority over a timeout expiring on the same edge
            if (init_done[idx]) begin
               if (idx == LAST_IDX) begin
                  state_n = ST_DONE;
               end else begin
                  idx_n   = idx + IW'(1);
                  state_n = ST_LAUNCH;
               end
            end else if (expired) begin
               state_n = ST_FAULT;
            end
         end
         ST_DONE: state_n = ST_DONE;
         ST_FAULT: begin
            if (retry) begin
               state_n = ST_HOLD;
               idx_n   = '0;
            end
         end
         default: begin
            state_n = ST_HOLD;
            idx_n   = '0;
         end
      endcase
   end

   // Terminal follows the phase being entered so the flag is valid on the first cycle of it.
   assign terminal = (state_n == ST_HOLD) ? HOLD_TERM : WAIT_TERM;

   cycle_timer #(
      .CW            (CW),
      .RESET_EXPIRED (HOLD_CYCLES == 1)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (state_n != state),
      .enable   ((state == ST_HOLD) || (state == ST_WAIT)),
      .terminal (terminal),
      .expired  (expired)
   );

   always_comb begin
      stage_rst_d  = '1;
      init_start_d = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if ((state_n == ST_LAUNCH) || (state_n == ST_WAIT)) begin
            stage_rst_d[i] = (IW'(i) > idx_n);
         end
         if (state_n == ST_DONE) begin
            stage_rst_d[i] = 1'b0;
         end
         if (state_n == ST_LAUNCH) begin
            init_start_d[i] = (IW'(i) == idx_n);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_HOLD;
         idx         <= '0;
         stage_rst   <= '1;
         init_start  <= '0;
         sys_ready   <= 1'b0;
         fault       <= 1'b0;
         fault_stage <= '0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         stage_rst   <= stage_rst_d;
         init_start  <= init_start_d;
         sys_ready   <= (state_n == ST_DONE);
         fault       <= (state_n == ST_FAULT);
         fault_stage <= (state_n == ST_FAULT) ? idx_n : '0;
      end
   end

endmodule
